// File: rtl/cursor_mover.sv
// Moves one on-screen object by signed per-tick deltas inside the VGA active window.
// Edges are clamped, wrapped or bounced depending on MODE; absolute loads take priority over steps.
module cursor_mover #(
  parameter int HBP    = 144,
  parameter int HFP    = 784,
  parameter int VBP    = 31,
  parameter int VFP    = 511,
  parameter int SIZE_X = 8,
  parameter int SIZE_Y = 8,
  parameter int DW     = 5,
  parameter int MODE   = 0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          tick,
  input  logic [DW-1:0] delta_x,
  input  logic [DW-1:0] delta_y,
  input  logic          load,
  input  logic [9:0]    load_x,
  input  logic [9:0]    load_y,
  output logic [9:0]    dot_x,
  output logic [9:0]    dot_y,
  output logic          dir_x,
  output logic          dir_y,
  output logic          hit_x,
  output logic          hit_y,
  output logic          step_done
);

  localparam logic signed [11:0] X_MIN = 12'(HBP);
  localparam logic signed [11:0] X_MAX = 12'(HFP - SIZE_X);
  localparam logic signed [11:0] Y_MIN = 12'(VBP);
  localparam logic signed [11:0] Y_MAX = 12'(VFP - SIZE_Y);
  localparam logic [9:0]         X_CTR = 10'((HBP + HFP) / 2);
  localparam logic [9:0]         Y_CTR = 10'((VBP + VFP) / 2);

  typedef struct packed {
    logic [9:0] pos;
    logic       hit;
    logic       dir;
  } axis_t;

  // 12-bit signed arithmetic leaves room to negate the most negative delta.
  function automatic axis_t move_axis(
    input logic [9:0]         pos,
    input logic [DW-1:0]      delta,
    input logic               dir,
    input logic signed [11:0] lo,
    input logic signed [11:0] hi
  );
    logic signed [11:0] d;
    logic signed [11:0] n;
    logic signed [11:0] span;
    logic signed [11:0] w;
    axis_t              r;
    span  = hi - lo + 12'sd1;
    d     = {{(12-DW){delta[DW-1]}}, delta};
    if (dir) d = -d;
    n     = $signed({2'b00, pos}) + d;
    w     = n;
    r.hit = 1'b0;
    r.dir = dir;
    if (n < lo) begin
      r.hit = 1'b1;
      w     = (MODE == 1) ? n + span : lo;
    end else if (n > hi) begin
      r.hit = 1'b1;
      w     = (MODE == 1) ? n - span : hi;
    end
    r.pos = w[9:0];
    // Only bounce mode reverses; landing exactly on a bound is not a hit.
    if (MODE == 2 && r.hit) r.dir = ~dir;
    return r;
  endfunction

  function automatic logic [9:0] clamp_load(
    input logic [9:0]         v,
    input logic signed [11:0] lo,
    input logic signed [11:0] hi
  );
    logic signed [11:0] s;
    logic signed [11:0] c;
    s = $signed({2'b00, v});
    c = s;
    if (s < lo)      c = lo;
    else if (s > hi) c = hi;
    return c[9:0];
  endfunction

  logic  tick_q;
  logic  step_req;
  axis_t nx;
  axis_t ny;

  assign step_req = tick & ~tick_q & en;

  always_comb begin
    nx = move_axis(dot_x, delta_x, dir_x, X_MIN, X_MAX);
    ny = move_axis(dot_y, delta_y, dir_y, Y_MIN, Y_MAX);
  end

  // tick_q resets high so a tick already held at release does not count as a rise.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tick_q    <= 1'b1;
      dot_x     <= X_CTR;
      dot_y     <= Y_CTR;
      dir_x     <= 1'b0;
      dir_y     <= 1'b0;
      hit_x     <= 1'b0;
      hit_y     <= 1'b0;
      step_done <= 1'b0;
    end else begin
      tick_q    <= tick;
      hit_x     <= 1'b0;
      hit_y     <= 1'b0;
      step_done <= 1'b0;
      if (load) begin
        dot_x <= clamp_load(load_x, X_MIN, X_MAX);
        dot_y <= clamp_load(load_y, Y_MIN, Y_MAX);
        dir_x <= 1'b0;
        dir_y <= 1'b0;
      end else if (step_req) begin
        dot_x     <= nx.pos;
        dot_y     <= ny.pos;
        dir_x     <= nx.dir;
        dir_y     <= ny.dir;
        hit_x     <= nx.hit;
        hit_y     <= ny.hit;
        step_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cursor_mover.sv
// Drives clamp, wrap and bounce instances with shared stimulus; a monitor pops
// expected step results from per-instance queues whenever step_done pulses.
module tb_cursor_mover;

  localparam int XL = 144, XH = 776, YL = 31, YH = 503;
  localparam int CX = 464, CY = 271;

  typedef struct {
    int x;
    int y;
    int dx;
    int dy;
    int hx;
    int hy;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic       tick = 1'b1;
  logic       load = 1'b0;
  logic [4:0] delta_x = '0;
  logic [4:0] delta_y = '0;
  logic [9:0] load_x = '0;
  logic [9:0] load_y = '0;

  logic [9:0] dot_x [3];
  logic [9:0] dot_y [3];
  logic [2:0] dir_x, dir_y, hit_x, hit_y, step_done;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q [3][$];
  int   mx [3], my [3], mdx [3], mdy [3];
  bit   tick_prev;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    cursor_mover #(.MODE(gi)) u_dut (
      .clk(clk), .clr(clr), .en(en), .tick(tick),
      .delta_x(delta_x), .delta_y(delta_y),
      .load(load), .load_x(load_x), .load_y(load_y),
      .dot_x(dot_x[gi]), .dot_y(dot_y[gi]),
      .dir_x(dir_x[gi]), .dir_y(dir_y[gi]),
      .hit_x(hit_x[gi]), .hit_y(hit_y[gi]),
      .step_done(step_done[gi])
    );
  end

  function automatic int clampv(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference edge behaviour: mode 0 clamp, 1 wrap by span, 2 clamp and reverse.
  task automatic axis_model(input int pos, input int del, input int dir, input int lo,
                            input int hi, input int mode,
                            output int np, output int hit, output int nd);
    int n;
    n   = pos + (dir != 0 ? -del : del);
    hit = 0;
    np  = n;
    nd  = dir;
    if (n < lo) begin
      hit = 1;
      np  = (mode == 1) ? n + (hi - lo + 1) : lo;
    end else if (n > hi) begin
      hit = 1;
      np  = (mode == 1) ? n - (hi - lo + 1) : hi;
    end
    if (mode == 2 && hit == 1) nd = 1 - dir;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = CX; my[i] = CY; mdx[i] = 0; mdy[i] = 0;
    end
    tick_prev = 1'b1;
  endtask

  // Sets inputs for the next active edge and advances the model to match it.
  task automatic drive(input bit t, input bit e, input bit l, input int lx, input int ly,
                       input int dxv, input int dyv);
    @(posedge clk);
    #2;
    tick = t; en = e; load = l;
    load_x = 10'(lx); load_y = 10'(ly);
    delta_x = 5'(dxv); delta_y = 5'(dyv);
    if (l) begin
      for (int i = 0; i < 3; i++) begin
        mx[i] = clampv(lx, XL, XH); my[i] = clampv(ly, YL, YH);
        mdx[i] = 0; mdy[i] = 0;
      end
    end else if (t && !tick_prev && e) begin
      for (int i = 0; i < 3; i++) begin
        int   nx, hx, ndx, ny, hy, ndy;
        exp_t ex;
        axis_model(mx[i], dxv, mdx[i], XL, XH, i, nx, hx, ndx);
        axis_model(my[i], dyv, mdy[i], YL, YH, i, ny, hy, ndy);
        mx[i] = nx; my[i] = ny; mdx[i] = ndx; mdy[i] = ndy;
        ex = '{nx, ny, ndx, ndy, hx, hy};
        exp_q[i].push_back(ex);
      end
    end
    tick_prev = t;
  endtask

  task automatic check_pos(input string name, input int i, input int ex, input int ey);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (int'(dot_x[i]) != ex || int'(dot_y[i]) != ey) begin
      bad++;
      $display("FAIL %s inst%0d: dot=(%0d,%0d) expected=(%0d,%0d)",
               name, i, dot_x[i], dot_y[i], ex, ey);
    end
  endtask

  task automatic check_dir(input string name, input int i, input int edx);
    total++;
    if (int'(dir_x[i]) != edx) begin
      bad++;
      $display("FAIL %s inst%0d: dir_x=%0d expected=%0d", name, i, dir_x[i], edx);
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      for (int i = 0; i < 3; i++) begin
        exp_t e;
        if (step_done[i]) begin
          total++;
          if (exp_q[i].size() == 0) begin
            bad++;
            $display("FAIL unexpected_step inst%0d: dot=(%0d,%0d) expected no step",
                     i, dot_x[i], dot_y[i]);
          end else begin
            e = exp_q[i].pop_front();
            if (int'(dot_x[i]) != e.x || int'(dot_y[i]) != e.y ||
                int'(dir_x[i]) != e.dx || int'(dir_y[i]) != e.dy ||
                int'(hit_x[i]) != e.hx || int'(hit_y[i]) != e.hy) begin
              bad++;
              $display("FAIL step inst%0d: dot=(%0d,%0d) dir=(%0d,%0d) hit=(%0d,%0d) expected dot=(%0d,%0d) dir=(%0d,%0d) hit=(%0d,%0d)",
                       i, dot_x[i], dot_y[i], dir_x[i], dir_y[i], hit_x[i], hit_y[i],
                       e.x, e.y, e.dx, e.dy, e.hx, e.hy);
            end else if (i == 0) begin
              $display("step inst0: dot=(%0d,%0d) hit=(%0d,%0d)",
                       dot_x[i], dot_y[i], hit_x[i], hit_y[i]);
            end
          end
        end else begin
          total++;
          if (hit_x[i] || hit_y[i]) begin
            bad++;
            $display("FAIL stray_hit inst%0d: hit=(%0d,%0d) expected (0,0) without step",
                     i, hit_x[i], hit_y[i]);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2 clr = 1'b0;
    // Tick held high through reset release must not step.
    repeat (5) drive(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) check_pos("reset_centre", i, CX, CY);

    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 3, -2);
    check_pos("basic_step", 0, 467, 269);

    drive(0, 1, 1, 780, 40, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 15, -15);
    check_pos("clamp", 0, 776, 31);

    drive(0, 1, 1, 145, 271, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, -16, 0);
    check_pos("wrap", 1, 762, 271);

    drive(0, 1, 1, 770, 271, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 10, 0);
    check_pos("bounce_hit", 2, 776, 271);
    check_dir("bounce_dir", 2, 1);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 10, 0);
    check_pos("bounce_back", 2, 766, 271);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, -16, 0);
    check_pos("bounce_minneg", 2, 776, 271);
    check_dir("bounce_minneg_dir", 2, 0);

    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 100, 600, 5, 5);
    check_pos("load_priority", 0, 144, 503);

    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 7, -7);
    @(posedge clk);
    @(negedge clk);
    #1 clr = 1'b1;
    tick = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (int'(dot_x[i]) != CX || int'(dot_y[i]) != CY) begin
        bad++;
        $display("FAIL async_clr inst%0d: dot=(%0d,%0d) expected=(%0d,%0d)",
                 i, dot_x[i], dot_y[i], CX, CY);
      end
    end
    @(posedge clk);
    #2 clr = 1'b0;
    repeat (3) drive(1, 1, 0, 0, 0, 4, 4);

    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0,
            $urandom_range(0, 24) == 0,
            int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16);
    end

    repeat (3) drive(0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (exp_q[i].size() != 0) begin
        bad++;
        $display("FAIL missing_steps inst%0d: pending=%0d expected=0", i, exp_q[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
